// File: rtl/flow_stat_updater.sv
// Per-flow statistics read-modify-write engine: reads a flow word, adds one packet
// and the packet length with saturation, and writes it back; stalls on address hazards.
`ifndef FLOW_RAM_ADDR_WIDTH
`define FLOW_RAM_ADDR_WIDTH 19
`endif
`ifndef FLOW_RAM_WORD_WIDTH
`define FLOW_RAM_WORD_WIDTH 72
`endif

module flow_stat_updater #(
  parameter int ADDR_W      = `FLOW_RAM_ADDR_WIDTH,
  parameter int WORD_W      = `FLOW_RAM_WORD_WIDTH,
  parameter int LEN_W       = 16,
  parameter int MAX_PENDING = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              upd_valid,
  output logic              upd_ready,
  input  logic [ADDR_W-1:0] upd_addr,
  input  logic [LEN_W-1:0]  upd_len,
  input  logic              upd_clear,
  output logic              read_en,
  output logic [ADDR_W-1:0] read_addr,
  input  logic              read_ready,
  input  logic [WORD_W-1:0] read_data,
  input  logic              read_data_new,
  output logic              write_en,
  output logic [ADDR_W-1:0] write_addr,
  output logic [WORD_W-1:0] write_data,
  input  logic              write_ready,
  output logic              busy,
  output logic              sat_pulse,
  output logic              err_underflow
);
  localparam int PW = $clog2(MAX_PENDING);
  localparam int CW = PW + 1;
  localparam int BW = WORD_W - 32;

  logic [ADDR_W-1:0] r_pq_addr [MAX_PENDING];
  logic [LEN_W-1:0]  r_pq_len  [MAX_PENDING];
  logic              r_pq_clr  [MAX_PENDING];
  logic [PW-1:0]     r_pq_rd, r_pq_wr;
  logic [CW-1:0]     r_pq_cnt;

  logic [ADDR_W-1:0] r_wq_addr [MAX_PENDING];
  logic [WORD_W-1:0] r_wq_data [MAX_PENDING];
  logic [PW-1:0]     r_wq_rd, r_wq_wr;
  logic [CW-1:0]     r_wq_cnt;

  logic r_oor, r_sat, r_err;

  logic [MAX_PENDING-1:0] w_pq_hit, w_wq_hit;
  logic                   w_hazard;
  logic [CW:0]            w_occ;
  logic                   w_acc, w_ret, w_wpop;
  logic [32:0]            w_psum;
  logic [BW:0]            w_bsum;
  logic                   w_clr, w_clip_p, w_clip_b, w_sat_now;
  logic [WORD_W-1:0]      w_new;

  // An entry slot is live when its distance from the read pointer is below the count.
  for (genvar g = 0; g < MAX_PENDING; g++) begin : g_hit
    logic [PW-1:0] w_poff, w_woff;
    assign w_poff      = PW'(g) - r_pq_rd;
    assign w_woff      = PW'(g) - r_wq_rd;
    assign w_pq_hit[g] = ({1'b0, w_poff} < r_pq_cnt) && (r_pq_addr[g] == upd_addr);
    assign w_wq_hit[g] = ({1'b0, w_woff} < r_wq_cnt) && (r_wq_addr[g] == upd_addr);
  end

  assign w_hazard  = |{w_pq_hit, w_wq_hit};
  assign w_occ     = {1'b0, r_pq_cnt} + {1'b0, r_wq_cnt};
  assign upd_ready = r_oor & reset_n & read_ready & (w_occ < (CW+1)'(MAX_PENDING)) & ~w_hazard;
  assign w_acc     = upd_valid & upd_ready;
  assign read_en   = w_acc;
  assign read_addr = upd_addr;

  assign w_ret  = read_data_new & (r_pq_cnt != '0);
  assign w_wpop = (r_wq_cnt != '0) & write_ready;

  assign w_clr    = r_pq_clr[r_pq_rd];
  assign w_psum   = {1'b0, read_data[31:0]} + 33'd1;
  assign w_bsum   = {1'b0, read_data[WORD_W-1:32]} + (BW+1)'(r_pq_len[r_pq_rd]);
  assign w_clip_p = w_psum[32];
  assign w_clip_b = w_bsum[BW];

  // A clear still consumes its read response so responses stay aligned with requests.
  always_comb begin
    w_new = '0;
    if (w_clr) begin
      w_new = {BW'(r_pq_len[r_pq_rd]), 32'd1};
    end else begin
      w_new[31:0]       = w_clip_p ? '1 : w_psum[31:0];
      w_new[WORD_W-1:32] = w_clip_b ? '1 : w_bsum[BW-1:0];
    end
  end

  assign w_sat_now = w_ret & ~w_clr & (w_clip_p | w_clip_b);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pq_rd  <= '0;
      r_pq_wr  <= '0;
      r_pq_cnt <= '0;
      r_wq_rd  <= '0;
      r_wq_wr  <= '0;
      r_wq_cnt <= '0;
      r_oor    <= 1'b0;
      r_sat    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_oor <= 1'b1;
      r_sat <= w_sat_now;
      if (read_data_new && (r_pq_cnt == '0)) r_err <= 1'b1;
      if (w_acc)  r_pq_wr <= r_pq_wr + 1'b1;
      if (w_ret)  r_pq_rd <= r_pq_rd + 1'b1;
      if (w_ret)  r_wq_wr <= r_wq_wr + 1'b1;
      if (w_wpop) r_wq_rd <= r_wq_rd + 1'b1;
      r_pq_cnt <= r_pq_cnt + CW'(w_acc) - CW'(w_ret);
      r_wq_cnt <= r_wq_cnt + CW'(w_ret) - CW'(w_wpop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_pq_addr[r_pq_wr] <= upd_addr;
      r_pq_len[r_pq_wr]  <= upd_len;
      r_pq_clr[r_pq_wr]  <= upd_clear;
    end
    if (w_ret) begin
      r_wq_addr[r_wq_wr] <= r_pq_addr[r_pq_rd];
      r_wq_data[r_wq_wr] <= w_new;
    end
  end

  assign write_en      = (r_wq_cnt != '0);
  assign write_addr    = r_wq_addr[r_wq_rd];
  assign write_data    = r_wq_data[r_wq_rd];
  assign busy          = (r_pq_cnt != '0) | (r_wq_cnt != '0);
  assign sat_pulse     = r_sat;
  assign err_underflow = r_err;

endmodule

// File: tb/tb_flow_stat_updater.sv
// Randomised bench for flow_stat_updater: SRAM model, reference statistics model,
// and a write-port scoreboard monitor.
module tb_flow_stat_updater;
  localparam int ADDR_W = 19;
  localparam int WORD_W = 72;
  localparam int LEN_W  = 16;
  localparam int MAXP   = 4;
  localparam int BW     = WORD_W - 32;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              upd_valid, upd_ready, upd_clear;
  logic [ADDR_W-1:0] upd_addr, read_addr, write_addr;
  logic [LEN_W-1:0]  upd_len;
  logic              read_en, read_ready, read_data_new;
  logic [WORD_W-1:0] read_data, write_data;
  logic              write_en, write_ready, busy, sat_pulse, err_underflow;

  flow_stat_updater #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .LEN_W(LEN_W), .MAX_PENDING(MAXP)) dut (
    .clk(clk), .reset_n(reset_n),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_addr(upd_addr),
    .upd_len(upd_len), .upd_clear(upd_clear),
    .read_en(read_en), .read_addr(read_addr), .read_ready(read_ready),
    .read_data(read_data), .read_data_new(read_data_new),
    .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
    .write_ready(write_ready),
    .busy(busy), .sat_pulse(sat_pulse), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  typedef struct { logic [ADDR_W-1:0] addr; logic [WORD_W-1:0] word; } wr_t;
  typedef struct { logic [WORD_W-1:0] data; int due; } rd_t;

  wr_t               expq[$];
  rd_t               rq[$];
  logic [ADDR_W-1:0] outst[$];
  logic [WORD_W-1:0] mem  [logic [ADDR_W-1:0]];
  logic [WORD_W-1:0] refm [logic [ADDR_W-1:0]];

  int checks = 0, errors = 0;
  int cyc = 0, last_due = 0, sat_seen = 0, sat_exp = 0;
  int rr_pct = 100, wr_pct = 100, lat_min = 1, lat_max = 1;
  bit oor_m = 1'b0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chkw(input string name, input logic [WORD_W-1:0] act, input logic [WORD_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chkn(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [WORD_W-1:0] init_word(input logic [ADDR_W-1:0] a);
    logic [BW-1:0] b;
    logic [31:0]   p;
    b = BW'(a) * BW'(13) + BW'(7);
    p = 32'(a) + 32'd3;
    return {b, p};
  endfunction

  function automatic logic [WORD_W-1:0] sram_rd(input logic [ADDR_W-1:0] a);
    return mem.exists(a) ? mem[a] : init_word(a);
  endfunction

  function automatic bit in_outst(input logic [ADDR_W-1:0] a);
    foreach (outst[i]) if (outst[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  // Statistics rule in plain 64-bit arithmetic: +1 packet, +len bytes, clip at field max.
  function automatic logic [WORD_W-1:0] ref_update(input logic [WORD_W-1:0] old,
      input logic [LEN_W-1:0] len, input bit clr, output bit clipped);
    longint unsigned p, b, pmax, bmax;
    pmax    = 64'hFFFF_FFFF;
    bmax    = (64'd1 << BW) - 64'd1;
    clipped = 1'b0;
    if (clr) begin
      p = 64'd1;
      b = 64'(len);
    end else begin
      p = 64'(old[31:0]) + 64'd1;
      b = 64'(old[WORD_W-1:32]) + 64'(len);
      if (p > pmax) begin p = pmax; clipped = 1'b1; end
      if (b > bmax) begin b = bmax; clipped = 1'b1; end
    end
    return {b[BW-1:0], p[31:0]};
  endfunction

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [WORD_W-1:0] w);
    mem[a]  = w;
    refm[a] = w;
  endtask

  // One clock: drive inputs after the falling edge, evaluate settled outputs, advance.
  task automatic tick(input bit v, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l,
                      input bit c, input bit frc_rdn, output bit acc);
    bit  exp_rdy, cl;
    rd_t r;
    wr_t e;
    logic [WORD_W-1:0] old;
    upd_valid   = v;
    upd_addr    = a;
    upd_len     = l;
    upd_clear   = c;
    read_ready  = ($urandom_range(99) < rr_pct);
    write_ready = ($urandom_range(99) < wr_pct);
    if (frc_rdn) begin
      read_data_new = 1'b1;
      read_data     = {8'($urandom()), $urandom(), $urandom()};
    end else if (rq.size() > 0 && rq[0].due <= cyc) begin
      read_data_new = 1'b1;
      read_data     = rq[0].data;
      void'(rq.pop_front());
    end else begin
      read_data_new = 1'b0;
      read_data     = {8'($urandom()), $urandom(), $urandom()};
    end
    #1;
    exp_rdy = oor_m && reset_n && read_ready && (outst.size() < MAXP) && !in_outst(a);
    chk1("upd_ready", upd_ready, exp_rdy);
    chk1("read_en", read_en, v && exp_rdy);
    acc = v && upd_ready;
    if (read_en) begin
      chkw("read_addr", WORD_W'(read_addr), WORD_W'(a));
      r.data = sram_rd(read_addr);
      r.due  = cyc + int'($urandom_range(lat_max, lat_min));
      if (r.due <= last_due) r.due = last_due + 1;
      last_due = r.due;
      rq.push_back(r);
    end
    if (acc) begin
      old    = refm.exists(a) ? refm[a] : init_word(a);
      e.addr = a;
      e.word = ref_update(old, l, c, cl);
      refm[a] = e.word;
      expq.push_back(e);
      outst.push_back(a);
      if (cl) sat_exp++;
    end
    if (write_en && write_ready) begin
      mem[write_addr] = write_data;
      if (outst.size() > 0) void'(outst.pop_front());
    end
    @(negedge clk);
    cyc++;
    oor_m = reset_n;
  endtask

  task automatic send(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l, input bit c);
    bit acc = 1'b0;
    int n = 0;
    while (!acc && n < 300) begin
      tick(1'b1, a, l, c, 1'b0, acc);
      n++;
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL send_timeout: addr %0h not accepted", a);
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) tick(1'b0, ADDR_W'($urandom_range(7)), '0, 1'b0, 1'b0, acc);
  endtask

  task automatic drain();
    bit acc;
    int n = 0;
    wr_pct = 100;
    rr_pct = 100;
    while ((outst.size() > 0 || rq.size() > 0) && n < 500) begin
      tick(1'b0, ADDR_W'($urandom_range(7)), '0, 1'b0, 1'b0, acc);
      n++;
    end
    if (n >= 500) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d updates still outstanding", outst.size());
    end
    chk1("busy_after_drain", busy, 1'b0);
  endtask

  // Scoreboard monitor: every accepted write must match the oldest expected result.
  always @(negedge clk) begin
    wr_t e;
    #2;
    if (reset_n === 1'b1 && write_en === 1'b1 && write_ready === 1'b1) begin
      if (expq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: addr %0h data %0h with none expected", write_addr, write_data);
      end else begin
        e = expq.pop_front();
        chkw("write_addr", WORD_W'(write_addr), WORD_W'(e.addr));
        chkw("write_data", write_data, e.word);
      end
    end
    if (reset_n === 1'b1 && sat_pulse === 1'b1) sat_seen++;
  end

  initial begin
    int sb;
    bit acc;
    reset_n = 1'b0; upd_valid = 1'b0; upd_addr = '0; upd_len = '0; upd_clear = 1'b0;
    read_ready = 1'b1; read_data = '0; read_data_new = 1'b0; write_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk1("rst_upd_ready", upd_ready, 1'b0);
    chk1("rst_read_en", read_en, 1'b0);
    chk1("rst_write_en", write_en, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_sat", sat_pulse, 1'b0);
    chk1("rst_err", err_underflow, 1'b0);
    reset_n = 1'b1;
    oor_m   = 1'b0;
    tick(1'b0, 19'h10, '0, 1'b0, 1'b0, acc);
    tick(1'b0, 19'h10, '0, 1'b0, 1'b0, acc);

    // single update, 3-cycle read latency
    preload(19'h10, {40'd1000, 32'd5});
    lat_min = 3; lat_max = 3;
    send(19'h10, 16'd64, 1'b0);
    drain();
    chkw("t2_word", mem[19'h10], {40'd1064, 32'd6});

    // occupancy limit with the write port stalled
    lat_min = 1; lat_max = 1; wr_pct = 0;
    for (int i = 0; i < 4; i++) send(ADDR_W'(32'h30 + i), LEN_W'(16'd10 * (i + 1)), 1'b0);
    idle(6);
    chk1("t3_busy", busy, 1'b1);
    tick(1'b1, 19'h34, 16'd7, 1'b0, 1'b0, acc);
    chk1("t3_full_block", acc, 1'b0);
    wr_pct = 100;
    send(19'h34, 16'd7, 1'b0);
    drain();

    // same-address hazard
    preload(19'h20, '0);
    wr_pct = 30; lat_min = 1; lat_max = 4;
    send(19'h20, 16'd100, 1'b0);
    send(19'h20, 16'd50, 1'b0);
    drain();
    chkw("t4_word", mem[19'h20], {40'd150, 32'd2});

    // saturation and clear
    preload(19'h40, {40'd500, 32'hFFFF_FFFF});
    sb = sat_seen;
    send(19'h40, 16'd10, 1'b0);
    drain();
    idle(2);
    chkw("t5_sat_word", mem[19'h40], {40'd510, 32'hFFFF_FFFF});
    chkn("t5_sat_pulses", sat_seen - sb, 1);
    preload(19'h41, {40'h12_3456_789A, 32'hDEAD_BEEF});
    send(19'h41, 16'd40, 1'b1);
    drain();
    chkw("t5_clear_word", mem[19'h41], {40'd40, 32'd1});

    // randomized traffic over a small address set to provoke hazards
    preload(19'h100, {40'd0, 32'hFFFF_FFFE});
    preload(19'h101, {40'hFF_FFFF_0000, 32'd0});
    preload(19'h102, {40'hFF_FFFF_FFFF, 32'hFFFF_FFFF});
    for (int i = 0; i < 600; i++) begin
      rr_pct = 85; wr_pct = 60; lat_min = 1; lat_max = 5;
      tick($urandom_range(1) == 1, ADDR_W'(32'h100 + $urandom_range(7)), LEN_W'($urandom()),
           $urandom_range(9) == 0, 1'b0, acc);
    end
    drain();
    idle(2);
    chkn("sat_count", sat_seen, sat_exp);
    chkn("expq_empty", expq.size(), 0);
    chk1("no_underflow_yet", err_underflow, 1'b0);

    // read return with nothing pending
    tick(1'b0, 19'h0, '0, 1'b0, 1'b1, acc);
    chk1("t6_err_set", err_underflow, 1'b1);
    chk1("t6_no_write", write_en, 1'b0);
    idle(3);
    chk1("t6_err_sticky", err_underflow, 1'b1);
    chk1("t6_still_idle", busy, 1'b0);

    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk1("rst2_err", err_underflow, 1'b0);
    chk1("rst2_upd_ready", upd_ready, 1'b0);
    reset_n = 1'b1;
    oor_m   = 1'b0;
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/flow_stat_updater.md
Name: flow_stat_updater

Overview:
- Read-modify-write engine for per-flow statistics in SRAM.
- Sits directly upstream of the SRAM simplified interface. It drives that interface's read port (read_en/read_addr/read_ready) and write port (write_en/write_addr/write_data/write_ready), and consumes its read_data/read_data_new.
- Each accepted update reads the flow word, adds one packet and the packet length with saturation, and writes the word back.
- Keeps up to MAX_PENDING updates in flight and stalls on address hazards.

Parameters:
- ADDR_W, `FLOW_RAM_ADDR_WIDTH (19): flow RAM address width.
- WORD_W, `FLOW_RAM_WORD_WIDTH (72): flow RAM word width. Bits [31:0] hold the packet count; bits [WORD_W-1:32] hold the byte count.
- LEN_W, 16: packet length width.
- MAX_PENDING, 4: maximum combined occupancy of the pending FIFO and the write FIFO. Must be a power of 2 and at least 2.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous reset, active-low.
- upd_valid  in  1  update request valid.
- upd_ready  out  1  update accepted on upd_valid & upd_ready.
- upd_addr  in  ADDR_W  flow address.
- upd_len  in  LEN_W  packet length in bytes.
- upd_clear  in  1  new flow: ignore the stored word and initialise it.
- read_en  out  1  to the SRAM interface read port.
- read_addr  out  ADDR_W  to the SRAM interface read port.
- read_ready  in  1  from the SRAM interface read port.
- read_data  in  WORD_W  returned word, in request order.
- read_data_new  in  1  read_data valid for this cycle only.
- write_en  out  1  to the SRAM interface write port.
- write_addr  out  ADDR_W  to the SRAM interface write port.
- write_data  out  WORD_W  to the SRAM interface write port.
- write_ready  in  1  from the SRAM interface write port.
- busy  out  1  high when either FIFO is non-empty.
- sat_pulse  out  1  one-cycle pulse when a counter saturates.
- err_underflow  out  1  sticky error flag, cleared only by reset.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - Both FIFOs emptied.
  - upd_ready=0, read_en=0, write_en=0, busy=0, sat_pulse=0, err_underflow=0.
  - Reset mid-operation discards all in-flight entries.
  - The bench asserts reset only when the SRAM is idle.
- Cycle after reset release: upd_ready may rise (one idle cycle, matching the SRAM interface's reset state).
- Admission rule (combinational):
  - upd_ready = out_of_reset & read_ready & (pend_cnt + wr_cnt < MAX_PENDING) & !hazard.
  - hazard = upd_addr equals the address of any valid pending-FIFO or write-FIFO entry.
  - upd_ready does not depend on upd_valid.
- Read issue:
  - read_en = upd_valid & upd_ready (combinational, same cycle); read_addr = upd_addr.
  - On acceptance, push {addr, len, clear} into the pending FIFO at the clk edge.
- Read return:
  - On read_data_new with the pending FIFO non-empty: pop its head, compute the new word, and push {addr, word} into the write FIFO at the same edge.
  - Responses map to requests strictly in order; the read latency is arbitrary.
- Read return with the pending FIFO empty: data ignored, err_underflow set to 1.
- Arithmetic, with P = old[31:0] and B = old[WORD_W-1:32]:
  - clear=1: P'=1, B'=zero-extended len; read_data is ignored, but the read is still issued so ordering is preserved.
  - clear=0: P'=min(P+1, 2^32-1) and B'=min(B+len, 2^(WORD_W-32)-1).
  - sat_pulse is asserted the cycle after the result push if either sum clipped.
- Write:
  - write_en = write FIFO non-empty; write_addr/write_data = FIFO head.
  - Pop the head on write_en & write_ready.
  - Earliest write_en is one cycle after read_data_new.
  - write_en, addr and data hold stable until accepted.
- Overflow freedom: the occupancy bound guarantees that a returning read always finds space in the write FIFO.
- Simultaneous events:
  - Accept, read return and write pop may all occur in the same cycle; the counters update by the net change.
  - A write pop of address A in cycle T lets an update to A be accepted in T+1, not in T.
  - The hazard check uses the registered FIFO contents.
- Ordering: the SRAM arbiter completes an accepted write before any later-accepted read to the same address. No extra guard is needed.
- busy = (pend_cnt != 0) | (wr_cnt != 0).

Test Plan:
1. Reset held 3 cycles, then released -> all outputs 0 during reset; upd_ready=1 from the 2nd cycle after release, with read_ready=1.
2. Update addr=0x10, len=64, clear=0; SRAM returns P=5, B=1000 after 3 cycles -> one write to 0x10 with P=6, B=1064, one cycle after read_data_new.
3. Four updates to distinct addresses with write_ready held 0 -> a 5th update sees upd_ready=0 until the first write is accepted; all four writes emerge in order with the correct sums.
4. Back-to-back updates to addr 0x20 (len 100, then len 50) on old word P=0, B=0 -> the second update is stalled by the hazard until the first write is accepted; final write gives P=2, B=150.
5. Update with old P=0xFFFFFFFF, len=10 -> write has P=0xFFFFFFFF, B=old+10, and sat_pulse is 1 for one cycle. clear=1 with len=40 -> write has P=1, B=40 regardless of read_data.
6. read_data_new pulsed with no pending entry -> err_underflow=1 and stays 1 until reset; no write is issued.
